// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART serializer: pops show-ahead FIFO words and sends start, data (LSB first), optional even parity, stop.
// Optional parity stage enabled by defining FIFO_UART_TX_PARITY_EN; port list is identical either way.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_read,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH-1:0]   shift_r;
    logic               last_cycle_s;
    logic               pop_s;
`ifdef FIFO_UART_TX_PARITY_EN
    logic               parity_r;
`endif

    assign last_cycle_s = (cnt_r == CNT_LAST);
    // Pop decision uses only registered state and FIFO flags, never the data word.
    assign pop_s = ~rst & tx_en & ~fifo_empty &
                   ((state_r == ST_IDLE) | ((state_r == ST_STOP) & last_cycle_s));
    assign fifo_read = pop_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Baud counter, bit index, shift register and parity accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else if (pop_s) begin
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else if (state_r != ST_IDLE) begin
            cnt_r <= last_cycle_s ? '0 : (cnt_r + CNT_W'(1));
            if ((state_r == ST_DATA) && last_cycle_s) begin
                shift_r <= shift_r >> 1;
                idx_r   <= idx_r + IDX_W'(1);
`ifdef FIFO_UART_TX_PARITY_EN
                parity_r <= parity_r ^ shift_r[0];
`endif
            end
        end else begin
            cnt_r <= '0;
        end
    end

    // Next-state and line/status decode.
    always_comb begin
        state_s    = state_r;
        tx         = 1'b1;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
                if (pop_s) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                tx = 1'b0;
                if (last_cycle_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                tx = shift_r[0];
                if (last_cycle_s && (idx_r == IDX_LAST)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    state_s = ST_PARITY;
`else
                    state_s = ST_STOP;
`endif
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                tx = parity_r;
                if (last_cycle_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (last_cycle_s) begin
                    frame_done = 1'b1;
                    state_s    = pop_s ? ST_START : ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                busy    = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the team's synchronous FIFO. It pops words from the FIFO read port and serializes each one onto a single UART-style line: start bit, WIDTH data bits LSB first, optional parity, one stop bit. It sits between the FIFO's `read`/`empty`/`data_out` pins and the chip-level serial pin.

## Interface
- `WIDTH`, default 8: data bits per frame; matches the FIFO `WIDTH`.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range is 2 or more.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous, active-high reset, sampled on `clk`.
- `tx_en`  input  1  when high, new frames may start; when low, no pops occur.
- `fifo_empty`  input  1  the FIFO `empty` flag (registered in the FIFO).
- `fifo_data`  input  WIDTH  the FIFO `data_out`; show-ahead, valid whenever `fifo_empty` is 0.
- `fifo_read`  output  1  one-cycle pop strobe to the FIFO `read` input.
- `tx`  output  1  serial line; idles high.
- `busy`  output  1  high while a frame is on the line.
- `frame_done`  output  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- **States:** IDLE, START, DATA, PARITY (only with the macro), STOP.
- **Pop condition:** `pop = tx_en & ~fifo_empty & (state==IDLE | (state==STOP & last_cycle))`.
  - `fifo_read = pop`, decoded from registered state and inputs only.
  - `fifo_read` never depends on `fifo_data`.
- **On a pop edge:**
  - `fifo_data` is captured into the WIDTH-bit shift register.
  - The baud counter clears to 0.
  - The state moves to START.
- **Baud counter:** counts 0 to CLKS_PER_BIT-1. `last_cycle` is true when the counter equals CLKS_PER_BIT-1. The counter wraps to 0 on every bit boundary.
- **START:** `tx=0`. On `last_cycle`, move to DATA with bit index 0.
- **DATA:** `tx = shift[0]`.
  - On `last_cycle`: shift right, increment the index, and accumulate the parity.
  - After the index reaches WIDTH-1, move to PARITY (macro on) or STOP.
- **STOP:** `tx=1`. On `last_cycle`:
  - `frame_done=1`.
  - If `pop`, go directly to START (no idle cycle between frames).
  - Otherwise go to IDLE.
- **Bit index width:** `$clog2(WIDTH)`. The counter width is `$clog2(CLKS_PER_BIT)`.
- **Boundary conditions:**
  - `tx_en` dropping mid-frame: the current frame completes normally, then the block goes to IDLE. No pop occurs.
  - `fifo_empty` rising mid-frame: ignored until the stop bit's last cycle.
  - FIFO full: irrelevant to this block.
  - Reset mid-frame: the next cycle shows reset values. The popped word is lost and is not re-read.
  - A pop never occurs while `rst=1`.

## Timing
- **Reset values:** `tx=1`, `busy=0`, `fifo_read=0`, `frame_done=0`, state IDLE, counters 0.
- **Frame timeline,** where T is the cycle in which `fifo_read=1` and C=CLKS_PER_BIT:
  - `tx` falls in cycle T+1.
  - The start bit occupies T+1 to T+C.
  - Data bit i occupies T+1+(i+1)·C to T+(i+2)·C.
  - The stop bit (macro off) occupies T+1+(WIDTH+1)·C to T+(WIDTH+2)·C.
- **Frame length:** (WIDTH+2)·C cycles, or (WIDTH+3)·C with parity.
- **busy:** high from T+1 through the last stop cycle, inclusive. Back-to-back frames keep `busy` continuously high.
- **Back-to-back pop:** occurs in the stop bit's last cycle, the same cycle as `frame_done`. The next start bit begins the following cycle.
- **From IDLE:** pop latency from `fifo_empty` falling, with `tx_en=1`, is 0 cycles, because `fifo_read` is asserted in that same cycle.

## Configuration
- **Macro:** `FIFO_UART_TX_PARITY_EN`.
- **Defined:** a PARITY state of C cycles is inserted between DATA and STOP. `tx` = XOR of the WIDTH data bits (even parity).
- **Undefined:** there is no PARITY state; STOP follows the last data bit directly.
- **Either way:** the port list is identical.

## Test plan
- **Reset:** hold `rst=1` for 3 cycles with `fifo_empty=0` -> `fifo_read=0`, `tx=1`, `busy=0` throughout; the first pop occurs in the first cycle after reset deasserts.
- **Single frame:** C=4, WIDTH=8, drive 8'hA5 -> `tx` sequence per 4 cycles is 0,1,0,1,0,0,1,0,1,1 (parity off); `frame_done` pulses once, 40 cycles after the pop.
- **Back-to-back:** 3 words 8'h00, 8'hFF, 8'h3C queued -> exactly 3 `fifo_read` pulses spaced 40 cycles apart; `busy` stays high for 120 cycles with no idle cycle.
- **tx_en gating:** drop `tx_en` during data bit 3 of frame 1 with 2 words queued -> frame 1 completes; no second pop; `tx=1` and `busy=0` after the stop bit.
- **Reset mid-frame:** assert `rst` during data bit 5 -> `tx=1` next cycle; the next frame starts with the following FIFO word.
- **Parity (macro on):** send 8'h07 -> parity bit 1, frame 44 cycles; send 8'h03 -> parity bit 0.
